ks_sub_pipe: RTL and testbench
==============================

Name: ks_sub_pipe

Overview:
- Pipelined Kogge-Stone prefix subtractor. Computes D = A − B with borrow, zero and signed-overflow flags.
- Datapath counterpart to the combinational prefix adder: it runs the same propagate/generate prefix network on A and ~B, with carry-in forced to 1.
- Registered across 3 stages behind a valid/ready handshake.
- Sits between operand producers and ALU result consumers. Back-pressure stalls the entire pipeline.

Parameters:
- WIDTH, 4, operand width in bits. Must be a power of 2, ≥2.
- LOGW, 2, number of prefix levels, equal to log2(WIDTH). Must match WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend, unsigned or two's complement
- b  input  WIDTH  subtrahend
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- d  output  WIDTH  difference A−B mod 2^WIDTH
- borrow  output  1  1 when A<B as unsigned
- zero  output  1  1 when d==0
- ovf  output  1  signed overflow of A−B

Behaviour:
- Reset: one clock, asynchronous active-low. All stage valid bits clear on rst_n low, regardless of clk. Data registers clear to 0. Outputs after reset: out_valid=0, d=0, borrow=0, zero=0, ovf=0. in_ready=1 once reset is released.
- Global advance enable: en = out_ready | ~out_valid. in_ready = en, which is combinational from out_ready and out_valid.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Stage 1 (S1), registered when en:
  - bi = ~b.
  - p[i] = a[i]^bi[i], g[i] = a[i]&bi[i].
  - Carry-in is 1: g_in = 1 into bit 0 of the prefix.
  - Keep a[MSB] and b[MSB] for the overflow calculation.
  - v1 <= in_valid.
- Stage 2 (S2), registered when en:
  - Kogge-Stone prefix over LOGW levels. At level k, (G,P)[i] = (G[i] | P[i]&G[i−2^k], P[i]&P[i−2^k]) for i ≥ 2^k; lower bits pass through unchanged.
  - Register the final group generate per bit: c[i+1] = G[0..i] including carry-in, with c[0] = 1.
  - Also register p.
  - v2 <= v1.
- Stage 3, the output register, when en:
  - d[i] = p[i]^c[i].
  - borrow = ~c[WIDTH].
  - zero = (d==0).
  - ovf = (a_msb ^ b_msb) & (d_msb ^ a_msb).
  - out_valid <= v2.
- Latency: 3 cycles from input transfer to out_valid, when not stalled. Throughput is 1 per cycle when out_ready is held high.
- Stall: when out_valid=1 and out_ready=0, en=0.
  - Every stage and every valid bit holds.
  - d, borrow, zero and ovf must remain stable.
  - in_ready=0; an operand presented in this cycle is not captured.
- Bubbles: the pipeline does not collapse bubbles. Empty stages (v=0) still wait for en. While out_valid=0, en=1, so the pipeline drains freely.
- Simultaneous input and output transfer in the same cycle is legal. Both happen, with no loss and no duplication.
- When a stage's valid bit is 0, its data registers may update with any value. Outputs are only meaningful while out_valid=1.
- Reset mid-operation: all in-flight results are discarded and no output transfer occurs for them. The first result after reset comes from the first input transfer after reset.
- Ordering: results leave in strict FIFO order of input transfers.

Test Plan:
- Basic, WIDTH=4, out_ready=1:
  - a=5, b=3 -> after 3 cycles d=2, borrow=0, zero=0, ovf=0.
  - a=3, b=5 -> d=14 (0b1110), borrow=1, ovf=0.
- Flags:
  - a=9, b=9 -> d=0, zero=1, borrow=0.
  - a=8, b=1 -> d=7, ovf=1, borrow=0.
  - a=7, b=15 -> d=8, ovf=1, borrow=1.
- Back-to-back throughput: stream 16 random pairs, one per cycle, with out_ready=1. Expect out_valid high for 16 consecutive cycles starting at cycle 3, with results in order and all matching the golden (a−b) mod 16 and the flag model.
- Back-pressure: stream 3 pairs, then hold out_ready=0 for 5 cycles while in_valid stays 1. Require in_ready=0 and a stable d/borrow/zero/ovf during the stall. After out_ready rises, all results are delivered in order with no drop or duplicate.
- Reset mid-stream: assert rst_n=0 asynchronously, between clock edges, while 3 results are in flight. Require out_valid to fall to 0 immediately. After release, no stale result appears; a new pair a=0, b=1 yields d=15, borrow=1 at cycle 3.
- Exhaustive check at WIDTH=4: all 256 pairs checked against the golden model. Parameter sweep at WIDTH=8 and LOGW=3 with 10k random pairs and random out_ready.

Source files
------------

// File: rtl/ks_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone subtractor.
// The slave side is the subtractor; the master side is the producer/consumer pair around it.
interface ks_sub_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             borrow;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, d, borrow, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, d, borrow, zero, ovf
    );
endinterface

// File: rtl/ks_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: D = A - B via A + ~B + 1,
// with borrow, zero and signed-overflow flags. A single enable stalls every stage.
module ks_sub_pipe #(
    parameter int WIDTH = 4,
    parameter int LOGW  = 2
) (
    input logic          clk,
    input logic          rst_n,
    ks_sub_pipe_if.slave bus
);
    logic             en;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] p1, g1;
    logic             a_msb1, b_msb1, v1;
    logic [WIDTH:0]   c2;
    logic [WIDTH-1:0] p2;
    logic             a_msb2, b_msb2, v2;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] d_q;
    logic             out_valid_q, borrow_q, zero_q, ovf_q;
    logic [WIDTH-1:0] gl [LOGW+1];
    logic [WIDTH-1:0] pl [LOGW];

    assign en            = bus.out_ready | ~out_valid_q;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.borrow    = borrow_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

    assign bi = ~bus.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1     <= '0;
            g1     <= '0;
            a_msb1 <= 1'b0;
            b_msb1 <= 1'b0;
            v1     <= 1'b0;
        end else if (en) begin
            p1     <= bus.a ^ bi;
            g1     <= bus.a & bi;
            a_msb1 <= bus.a[WIDTH-1];
            b_msb1 <= bus.b[WIDTH-1];
            v1     <= bus.in_valid;
        end
    end

    // Carry-in of 1 is folded into bit 0, so bit 0 already holds G[0..0] incl. carry-in.
    assign gl[0] = {g1[WIDTH-1:1], g1[0] | p1[0]};
    assign pl[0] = p1;

    for (genvar k = 0; k < LOGW; k++) begin : g_level
        localparam int S = 1 << k;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= S) begin : g_combine
                assign gl[k+1][i] = gl[k][i] | (pl[k][i] & gl[k][i-S]);
                if (k + 1 < LOGW) begin : g_prop
                    assign pl[k+1][i] = pl[k][i] & pl[k][i-S];
                end
            end else begin : g_pass
                assign gl[k+1][i] = gl[k][i];
                if (k + 1 < LOGW) begin : g_prop
                    assign pl[k+1][i] = pl[k][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c2     <= '0;
            p2     <= '0;
            a_msb2 <= 1'b0;
            b_msb2 <= 1'b0;
            v2     <= 1'b0;
        end else if (en) begin
            c2     <= {gl[LOGW], 1'b1};
            p2     <= p1;
            a_msb2 <= a_msb1;
            b_msb2 <= b_msb1;
            v2     <= v1;
        end
    end

    assign d_next = p2 ^ c2[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            d_q         <= d_next;
            borrow_q    <= ~c2[WIDTH];
            zero_q      <= (d_next == '0);
            ovf_q       <= (a_msb2 ^ b_msb2) & (d_next[WIDTH-1] ^ a_msb2);
            out_valid_q <= v2;
        end
    end
endmodule

// File: tb/tb_ks_sub_pipe.sv
// Scoreboard bench for ks_sub_pipe at WIDTH=4 (directed, stall, reset, exhaustive)
// and WIDTH=8 (random sweep); expectations come from an integer arithmetic model.
module tb_ks_sub_pipe;
    typedef struct {
        int d;
        bit borrow;
        bit zero;
        bit ovf;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic rst8_n = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;

    bit   stall_prev4 = 1'b0;
    int   hd;
    bit   hb, hz, ho;
    int   run4 = 0, last_run4 = 0, run_start4 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ks_sub_pipe_if #(.WIDTH(4)) bus4 ();
    ks_sub_pipe_if #(.WIDTH(8)) bus8 ();

    ks_sub_pipe #(.WIDTH(4), .LOGW(2)) dut4 (.clk(clk), .rst_n(rst_n),  .bus(bus4));
    ks_sub_pipe #(.WIDTH(8), .LOGW(3)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

    function automatic exp_t refModel(int w, int a, int b);
        exp_t e;
        int   m    = 1 << w;
        int   half = m / 2;
        int   sa, sb, r;
        e.d      = (((a - b) % m) + m) % m;
        e.borrow = (a < b);
        e.zero   = (e.d == 0);
        sa       = (a >= half) ? a - m : a;
        sb       = (b >= half) ? b - m : b;
        r        = sa - sb;
        e.ovf    = (r < -half) || (r > half - 1);
        return e;
    endfunction

    task automatic checkOutput(string name, exp_t e, int d, bit br, bit z, bit o);
        checks++;
        if (d !== e.d || br !== e.borrow || z !== e.zero || o !== e.ovf) begin
            errors++;
            $display("[TB] FAIL %s: got d=%0d borrow=%0d zero=%0d ovf=%0d, want d=%0d borrow=%0d zero=%0d ovf=%0d",
                     name, d, br, z, o, e.d, e.borrow, e.zero, e.ovf);
        end
    endtask

    task automatic checkValue(string name, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Scoreboard for the WIDTH=4 instance: pops on output transfer, pushes on input transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev4 = 1'b0;
            run4        = 0;
        end else begin
            if (bus4.out_valid && !bus4.out_ready) begin
                checkValue("w4 in_ready during stall", int'(bus4.in_ready), 0);
                if (stall_prev4) begin
                    e4 = '{hd, hb, hz, ho};
                    checkOutput("w4 stable during stall", e4, int'(bus4.d), bus4.borrow, bus4.zero, bus4.ovf);
                end
                hd = int'(bus4.d); hb = bus4.borrow; hz = bus4.zero; ho = bus4.ovf;
                stall_prev4 = 1'b1;
            end else begin
                stall_prev4 = 1'b0;
            end
            if (bus4.out_valid && bus4.out_ready) begin
                if (run4 == 0) run_start4 = cyc;
                run4++;
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL w4 unexpected output: got d=%0d, want no output", bus4.d);
                end else begin
                    e4 = q4.pop_front();
                    checkOutput("w4 result", e4, int'(bus4.d), bus4.borrow, bus4.zero, bus4.ovf);
                end
            end else if (run4 > 0) begin
                last_run4 = run4;
                run4      = 0;
            end
            if (bus4.in_valid && bus4.in_ready)
                q4.push_back(refModel(4, int'(bus4.a), int'(bus4.b)));
        end
    end

    always @(negedge clk) begin
        if (rst8_n) begin
            if (bus8.out_valid && bus8.out_ready) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL w8 unexpected output: got d=%0d, want no output", bus8.d);
                end else begin
                    e8 = q8.pop_front();
                    checkOutput("w8 result", e8, int'(bus8.d), bus8.borrow, bus8.zero, bus8.ovf);
                end
            end
            if (bus8.in_valid && bus8.in_ready)
                q8.push_back(refModel(8, int'(bus8.a), int'(bus8.b)));
        end
    end

    task automatic applyStimulus(bit v, int a, int b, bit r);
        @(posedge clk);
        #1;
        bus4.in_valid  = v;
        bus4.a         = a[3:0];
        bus4.b         = b[3:0];
        bus4.out_ready = r;
    endtask

    task automatic applyStimulus8(bit v, int a, int b, bit r);
        @(posedge clk);
        #1;
        bus8.in_valid  = v;
        bus8.a         = a[7:0];
        bus8.b         = b[7:0];
        bus8.out_ready = r;
    endtask

    task automatic drain(int n);
        repeat (n) applyStimulus(1'b0, 0, 0, 1'b1);
    endtask

    // Holds the pair on the bus until it is accepted; returns at the accepting negedge.
    task automatic sendPair(int a, int b, bit rnd_ready);
        int tries = 0;
        applyStimulus(1'b1, a, b, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        @(negedge clk);
        while (!bus4.in_ready && tries < 100) begin
            applyStimulus(1'b1, a, b, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            @(negedge clk);
            tries++;
        end
        if (tries == 100) checkValue("w4 accept timeout", 0, 1);
    endtask

    task automatic directed(string name, int a, int b, int ed, bit eb, bit ez, bit eo);
        exp_t e;
        int   lat = 0;
        drain(6);
        sendPair(a, b, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1);
        do begin
            @(negedge clk);
            lat++;
        end while (!bus4.out_valid && lat < 10);
        e = '{ed, eb, ez, eo};
        checkValue({name, " latency"}, lat, 3);
        checkOutput({name, " value"}, e, int'(bus4.d), bus4.borrow, bus4.zero, bus4.ovf);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int issue_cyc;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
        #1;
        rst_n  = 1'b0;
        rst8_n = 1'b0;
        #1;
        checkValue("reset out_valid", int'(bus4.out_valid), 0);
        checkValue("reset d",         int'(bus4.d),         0);
        checkValue("reset borrow",    int'(bus4.borrow),    0);
        checkValue("reset zero",      int'(bus4.zero),      0);
        checkValue("reset ovf",       int'(bus4.ovf),       0);
        #19;
        rst_n  = 1'b1;
        rst8_n = 1'b1;
        #1;
        checkValue("reset in_ready", int'(bus4.in_ready), 1);

        directed("sub 5-3",  5,  3,  2, 1'b0, 1'b0, 1'b0);
        directed("sub 3-5",  3,  5, 14, 1'b1, 1'b0, 1'b0);
        directed("sub 9-9",  9,  9,  0, 1'b0, 1'b1, 1'b0);
        directed("sub 8-1",  8,  1,  7, 1'b0, 1'b0, 1'b1);
        directed("sub 7-15", 7, 15,  8, 1'b1, 1'b0, 1'b1);

        // Back-to-back throughput with the consumer always ready.
        drain(6);
        sendPair($urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
        issue_cyc = cyc;
        for (int i = 1; i < 16; i++) sendPair($urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
        drain(8);
        checkValue("stream run length", last_run4, 16);
        checkValue("stream first output cycle", run_start4 - issue_cyc, 3);

        // Back-pressure with three results in flight and new operands offered during the stall.
        drain(6);
        for (int i = 0; i < 3; i++) sendPair($urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
        repeat (5) applyStimulus(1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
        drain(10);
        checkValue("stall pending after drain", q4.size(), 0);

        // Asynchronous reset between edges with three results in flight.
        drain(6);
        for (int i = 0; i < 3; i++) sendPair($urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus4.in_valid = 1'b0;
        #1;
        checkValue("mid-stream reset out_valid", int'(bus4.out_valid), 0);
        q4.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkValue("no stale output after reset", int'(bus4.out_valid), 0);
        end
        directed("sub 0-1 after reset", 0, 1, 15, 1'b1, 1'b0, 1'b0);

        repeat (200) applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                                   $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        drain(10);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                sendPair(a, b, 1'b1);
        drain(10);
        checkValue("w4 pending after exhaustive", q4.size(), 0);

        for (int i = 0; i < 10000; i++)
            applyStimulus8(1'($urandom_range(0, 1)), $urandom_range(0, 255),
                           $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        repeat (10) applyStimulus8(1'b0, 0, 0, 1'b1);
        @(negedge clk);
        checkValue("w8 pending after sweep", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
